branch_update_ctrl: RTL and testbench

- Back-end producer of the `branch_update` traffic that the front-end predictor consumes.
- Accepts resolved branches from the execute stage and compares each outcome with the prediction carried down the pipe.
- Queues every resolved branch as a training record and drains it one per cycle to the predictor tables.
- On a misprediction, issues a one-cycle branch flush with the corrected fetch address, then ignores wrong-path resolutions for a fixed hold window.

---
 rtl/branch_update_ctrl_if.sv | 41 ++++
 rtl/branch_update_ctrl.sv | 114 +++++++++++
 tb/tb_branch_update_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/branch_update_ctrl_if.sv
// Bundle between the execute stage, the branch_update_ctrl block and the predictor tables.
// The master side drives resolutions and table back-pressure; the slave side is the controller.
interface branch_update_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
);

  logic              res_valid_i;
  logic              res_ready_o;
  logic [ADDR_W-1:0] res_pc_i;
  logic              res_pre_taken_i;
  logic [ADDR_W-1:0] res_pre_target_i;
  logic              res_taken_i;
  logic [ADDR_W-1:0] res_target_i;

  logic              upd_en_o;
  logic              upd_ready_i;
  logic [ADDR_W-1:0] upd_pc_o;
  logic              upd_taken_o;
  logic [ADDR_W-1:0] upd_target_o;

  logic              branch_flush_o;
  logic [ADDR_W-1:0] redirect_pc_o;
  logic [CNT_W-1:0]  branch_cnt_o;
  logic [CNT_W-1:0]  mispredict_cnt_o;

  modport master (
    output res_valid_i, res_pc_i, res_pre_taken_i, res_pre_target_i,
           res_taken_i, res_target_i, upd_ready_i,
    input  res_ready_o, upd_en_o, upd_pc_o, upd_taken_o, upd_target_o,
           branch_flush_o, redirect_pc_o, branch_cnt_o, mispredict_cnt_o
  );

  modport slave (
    input  res_valid_i, res_pc_i, res_pre_taken_i, res_pre_target_i,
           res_taken_i, res_target_i, upd_ready_i,
    output res_ready_o, upd_en_o, upd_pc_o, upd_taken_o, upd_target_o,
           branch_flush_o, redirect_pc_o, branch_cnt_o, mispredict_cnt_o
  );

endinterface

// File: rtl/branch_update_ctrl.sv
// Turns resolved branches into predictor training records and one-cycle mispredict redirects,
// dropping wrong-path resolutions for FLUSH_HOLD cycles after each redirect.
module branch_update_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int FLUSH_HOLD = 2,
  parameter int CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  branch_update_ctrl_if.slave  bus
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int HOLD_W = $clog2(FLUSH_HOLD + 1);

  typedef enum logic {RUN, HOLD} state_t;

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;

  logic [ADDR_W-1:0] pc_mem     [FIFO_DEPTH];
  logic              taken_mem  [FIFO_DEPTH];
  logic [ADDR_W-1:0] target_mem [FIFO_DEPTH];

  logic              full;
  logic              empty;
  logic              mispredict;
  logic              accept;
  logic              pop;
  logic [ADDR_W-1:0] redirect_next;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign mispredict = (bus.res_taken_i != bus.res_pre_taken_i) ||
                      (bus.res_taken_i && (bus.res_target_i != bus.res_pre_target_i));

  assign accept = (state == RUN) && bus.res_valid_i && !full;
  assign pop    = !empty && bus.upd_ready_i;

  assign redirect_next = bus.res_taken_i ? bus.res_target_i : (bus.res_pc_i + ADDR_W'(4));

  // Ready is forced low while reset is held so every output reads 0 during reset.
  assign bus.res_ready_o = rst && ((state == HOLD) || !full);

  assign bus.upd_en_o     = !empty;
  assign bus.upd_pc_o     = empty ? '0 : pc_mem[rd_ptr[PTR_W-1:0]];
  assign bus.upd_taken_o  = empty ? 1'b0 : taken_mem[rd_ptr[PTR_W-1:0]];
  assign bus.upd_target_o = empty ? '0 : target_mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= RUN;
      hold_cnt           <= '0;
      bus.branch_flush_o <= 1'b0;
      bus.redirect_pc_o  <= '0;
    end else begin
      bus.branch_flush_o <= 1'b0;
      case (state)
        RUN: begin
          if (accept && mispredict) begin
            bus.branch_flush_o <= 1'b1;
            bus.redirect_pc_o  <= redirect_next;
            hold_cnt           <= HOLD_W'(FLUSH_HOLD);
            state              <= HOLD;
          end
        end
        HOLD: begin
          if (hold_cnt <= HOLD_W'(1)) begin
            hold_cnt <= '0;
            state    <= RUN;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr               <= '0;
      rd_ptr               <= '0;
      bus.branch_cnt_o     <= '0;
      bus.mispredict_cnt_o <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + (PTR_W+1)'(1);
        if (bus.branch_cnt_o != '1)
          bus.branch_cnt_o <= bus.branch_cnt_o + CNT_W'(1);
        if (mispredict && (bus.mispredict_cnt_o != '1))
          bus.mispredict_cnt_o <= bus.mispredict_cnt_o + CNT_W'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  // Storage needs no reset; entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (accept) begin
      pc_mem[wr_ptr[PTR_W-1:0]]     <= bus.res_pc_i;
      taken_mem[wr_ptr[PTR_W-1:0]]  <= bus.res_taken_i;
      target_mem[wr_ptr[PTR_W-1:0]] <= bus.res_target_i;
    end
  end

endmodule

// File: tb/tb_branch_update_ctrl.sv
// Directed bench for branch_update_ctrl: training records are scoreboarded when driven
// and compared as the predictor side pops them; flush/counter/ready checks are inline.
module tb_branch_update_ctrl;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } rec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  rec_t sb[$];

  branch_update_ctrl_if #(.ADDR_W(32), .CNT_W(32)) bus();

  branch_update_ctrl #(
    .ADDR_W(32), .FIFO_DEPTH(4), .FLUSH_HOLD(2), .CNT_W(32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of resolution inputs just after the rising edge.
  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic pt,
                               input logic [31:0] ptgt, input logic tk,
                               input logic [31:0] tgt, input logic exp_acc);
    rec_t r;
    @(posedge clk);
    #1;
    bus.res_valid_i      = v;
    bus.res_pc_i         = pc;
    bus.res_pre_taken_i  = pt;
    bus.res_pre_target_i = ptgt;
    bus.res_taken_i      = tk;
    bus.res_target_i     = tgt;
    if (exp_acc) begin
      r.pc     = pc;
      r.taken  = tk;
      r.target = tgt;
      sb.push_back(r);
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ready"},  64'(bus.res_ready_o), 64'h0);
    checkOutput({tag, "_upd_en"}, 64'(bus.upd_en_o), 64'h0);
    checkOutput({tag, "_upd_pc"}, 64'(bus.upd_pc_o), 64'h0);
    checkOutput({tag, "_flush"},  64'(bus.branch_flush_o), 64'h0);
    checkOutput({tag, "_redir"},  64'(bus.redirect_pc_o), 64'h0);
    checkOutput({tag, "_bcnt"},   64'(bus.branch_cnt_o), 64'h0);
    checkOutput({tag, "_mcnt"},   64'(bus.mispredict_cnt_o), 64'h0);
  endtask

  // Scoreboard side: every record the predictor accepts must match the oldest expected one.
  always @(negedge clk) begin
    rec_t got;
    rec_t exp_r;
    if (rst && bus.upd_en_o && bus.upd_ready_i) begin
      got.pc     = bus.upd_pc_o;
      got.taken  = bus.upd_taken_o;
      got.target = bus.upd_target_o;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $error("[TB] FAIL upd_unexpected: observed pc %h expected no record", got.pc);
      end else begin
        exp_r = sb.pop_front();
        assert (got === exp_r) else begin
          errors++;
          $error("[TB] FAIL upd_record: observed %h/%b/%h expected %h/%b/%h",
                 got.pc, got.taken, got.target, exp_r.pc, exp_r.taken, exp_r.target);
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.res_valid_i = 1'b0; bus.res_pc_i = '0; bus.res_pre_taken_i = 1'b0;
    bus.res_pre_target_i = '0; bus.res_taken_i = 1'b0; bus.res_target_i = '0;
    bus.upd_ready_i = 1'b1;

    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b1;

    // Correct not-taken branch.
    applyStimulus(1, 32'h1C000000, 0, 32'h0, 0, 32'h0, 1);
    @(negedge clk) checkOutput("t1_ready", 64'(bus.res_ready_o), 64'h1);
    idle();
    @(negedge clk);
    checkOutput("t1_flush", 64'(bus.branch_flush_o), 64'h0);
    checkOutput("t1_upd_en", 64'(bus.upd_en_o), 64'h1);
    checkOutput("t1_bcnt", 64'(bus.branch_cnt_o), 64'd1);
    checkOutput("t1_mcnt", 64'(bus.mispredict_cnt_o), 64'd0);
    idle();
    @(negedge clk) checkOutput("t1_upd_en_off", 64'(bus.upd_en_o), 64'h0);

    // Direction mispredict, then two dropped wrong-path resolutions.
    applyStimulus(1, 32'h1C000010, 0, 32'h0, 1, 32'h1C000100, 1);
    @(negedge clk);
    applyStimulus(1, 32'h1C000020, 0, 32'h0, 0, 32'h0, 0);
    @(negedge clk);
    checkOutput("t2_flush", 64'(bus.branch_flush_o), 64'h1);
    checkOutput("t2_redir", 64'(bus.redirect_pc_o), 64'h1C000100);
    checkOutput("t2_hold_ready", 64'(bus.res_ready_o), 64'h1);
    checkOutput("t2_mcnt", 64'(bus.mispredict_cnt_o), 64'd1);
    applyStimulus(1, 32'h1C000024, 0, 32'h0, 0, 32'h0, 0);
    @(negedge clk);
    checkOutput("t2_flush_off", 64'(bus.branch_flush_o), 64'h0);
    checkOutput("t2_bcnt_hold", 64'(bus.branch_cnt_o), 64'd2);
    applyStimulus(1, 32'h1C000030, 0, 32'h0, 0, 32'h0, 1);
    @(negedge clk) checkOutput("t2_bcnt_hold2", 64'(bus.branch_cnt_o), 64'd2);
    idle();
    @(negedge clk);
    checkOutput("t2_bcnt_third", 64'(bus.branch_cnt_o), 64'd3);
    checkOutput("t2_redir_kept", 64'(bus.redirect_pc_o), 64'h1C000100);

    // Not-taken mispredict at the top of the address space wraps the fall-through.
    applyStimulus(1, 32'hFFFFFFFC, 1, 32'h80, 0, 32'h0, 1);
    idle();
    @(negedge clk);
    checkOutput("t3_flush", 64'(bus.branch_flush_o), 64'h1);
    checkOutput("t3_redir", 64'(bus.redirect_pc_o), 64'h0);
    checkOutput("t3_mcnt", 64'(bus.mispredict_cnt_o), 64'd2);
    idle();
    idle();

    // Right direction, wrong target.
    applyStimulus(1, 32'h100, 1, 32'h200, 1, 32'h240, 1);
    idle();
    @(negedge clk);
    checkOutput("t4_flush", 64'(bus.branch_flush_o), 64'h1);
    checkOutput("t4_redir", 64'(bus.redirect_pc_o), 64'h240);
    checkOutput("t4_bcnt", 64'(bus.branch_cnt_o), 64'd5);
    idle();

    // Fill the queue with the predictor stalled, then drain in order.
    bus.upd_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 32'hA0 + 32'(i * 4), 0, 32'h0, 0, 32'h0, 1);
      @(negedge clk) checkOutput("t5_fill_ready", 64'(bus.res_ready_o), 64'h1);
    end
    applyStimulus(1, 32'hB0, 0, 32'h0, 0, 32'h0, 0);
    @(negedge clk);
    checkOutput("t5_full_ready", 64'(bus.res_ready_o), 64'h0);
    checkOutput("t5_head_stable", 64'(bus.upd_pc_o), 64'hA0);
    applyStimulus(1, 32'hB0, 0, 32'h0, 0, 32'h0, 0);
    bus.upd_ready_i = 1'b1;
    @(negedge clk) checkOutput("t5_pop_ready", 64'(bus.res_ready_o), 64'h0);
    idle();
    @(negedge clk) checkOutput("t5_ready_back", 64'(bus.res_ready_o), 64'h1);
    idle();
    idle();
    @(negedge clk) checkOutput("t5_bcnt", 64'(bus.branch_cnt_o), 64'd9);

    // Reset during HOLD with three records queued.
    bus.upd_ready_i = 1'b0;
    applyStimulus(1, 32'hC0, 0, 32'h0, 0, 32'h0, 1);
    applyStimulus(1, 32'hC4, 0, 32'h0, 0, 32'h0, 1);
    applyStimulus(1, 32'hC8, 0, 32'h0, 1, 32'h1000, 1);
    idle();
    @(negedge clk);
    checkOutput("t6_flush", 64'(bus.branch_flush_o), 64'h1);
    checkOutput("t6_redir", 64'(bus.redirect_pc_o), 64'h1000);
    #1 rst = 1'b0;
    #1 checkAllZero("midreset");
    sb.delete();
    bus.upd_ready_i = 1'b1;
    @(negedge clk) rst = 1'b1;
    applyStimulus(1, 32'hD0, 0, 32'h0, 0, 32'h0, 1);
    @(negedge clk) checkOutput("t6_ready_after", 64'(bus.res_ready_o), 64'h1);
    idle();
    @(negedge clk) checkOutput("t6_bcnt", 64'(bus.branch_cnt_o), 64'd1);
    idle();
    @(negedge clk);
    checkOutput("sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
